// File: rtl/fifo_read_ctrl_if.sv
// FIFO read port plus downstream stream, bundled for the read-side controller.
// Stream rule: a word moves when out_valid && out_ready at a rising edge; once out_valid is high,
// data_out/out_last stay stable until that transfer. rd_en pops one word; fifo_data follows a cycle later.
interface fifo_read_ctrl_if #(parameter int SIZE = 8);
  logic            e_flag;
  logic [SIZE-1:0] fifo_data;
  logic            rd_en;
  logic [SIZE-1:0] data_out;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;

  modport master (
    input  e_flag, fifo_data, out_ready,
    output rd_en, data_out, out_valid, out_last
  );

  modport slave (
    output e_flag, fifo_data, out_ready,
    input  rd_en, data_out, out_valid, out_last
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-domain FIFO consumer: credit-based pops into a 2-entry skid buffer, emitted as
// fixed-length bursts on a valid/ready stream with a last marker.
module fifo_read_ctrl #(
  parameter int SIZE  = 8,
  parameter int BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic             r_clk,
  input  logic             rst,
  input  logic             enable,
  fifo_read_ctrl_if.master bus,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic [1:0]       state_dbg
);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] BURST_V   = BW'(BURST);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

  state_t          state, state_nx;
  logic [SIZE-1:0] buf0, buf1;
  logic [1:0]      occ;
  logic            inflight;
  logic [BW-1:0]   issued, beat;
  logic            xfer, last_xfer, credit_ok, pop;
  logic [2:0]      pending;

  // A transfer in this cycle frees a slot, so it counts as credit for a same-cycle pop.
  assign xfer      = (occ != 2'd0) && bus.out_ready;
  assign last_xfer = xfer && (beat == LAST_BEAT);
  assign pending   = {1'b0, occ} + {2'b0, inflight} - {2'b0, xfer};
  assign credit_ok = pending < 3'd2;
  assign pop = !rst && !bus.e_flag && credit_ok && (issued < BURST_V) &&
               ((state == RUN) || ((state == STOP) && (issued != '0)));

  always_ff @(posedge r_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (enable) state_nx = RUN;
      RUN:  if (!enable) state_nx = STOP;
      STOP: begin
        if (enable)
          state_nx = RUN;
        else if (last_xfer || ((beat == '0) && (issued == '0) && (occ == 2'd0)))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_en     = pop;
    bus.out_valid = (occ != 2'd0);
    bus.out_last  = (occ != 2'd0) && (beat == LAST_BEAT);
    bus.data_out  = buf0;
    busy          = (state != IDLE);
    state_dbg     = state;
  end

  always_ff @(posedge r_clk) begin
    if (rst) begin
      buf0     <= '0;
      buf1     <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      issued   <= '0;
      beat     <= '0;
      word_cnt <= '0;
    end else begin
      inflight <= pop;
      if (last_xfer)  issued <= '0;
      else if (pop)   issued <= issued + 1'b1;
      if (xfer) begin
        beat     <= last_xfer ? '0 : beat + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end
      // Head is always buf0; capture lands behind whatever survives this cycle.
      case ({inflight, xfer})
        2'b10: begin
          if (occ == 2'd0) buf0 <= bus.fifo_data;
          else             buf1 <= bus.fifo_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) buf0 <= bus.fifo_data;
          else begin
            buf0 <= buf1;
            buf1 <= bus.fifo_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
